uart_cmd_ctrl: RTL

- Command controller between the UART receiver/transmitter and the display datapath (VGA test-pattern generator, dual 7-segment decoder).
- Parses short ASCII commands from the RX byte stream and sets the pattern select and the display byte.
- Pattern changes are held until a VGA frame boundary so the picture never tears mid-frame.
- Returns a one-byte ASCII status or reply per command through the UART TX handshake.

---
 rtl/uart_cmd_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// Command controller: parses ASCII 'P'/'D'/'?' commands from the UART RX stream, drives the
// pattern select (applied on frame boundaries) and display byte, and replies one byte via TX.
module uart_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CLKS  = 2500000,
   parameter logic [3:0]  RESET_PATTERN = 4'h0
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   input  logic       i_Frame_Start,
   input  logic       i_TX_Active,
   input  logic       i_TX_Done,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_Byte,
   output logic [3:0] o_Pattern,
   output logic [7:0] o_Display_Byte,
   output logic       o_Busy,
   output logic       o_Err
);

   localparam logic [7:0] ChP     = 8'h50;
   localparam logic [7:0] ChD     = 8'h44;
   localparam logic [7:0] ChQuery = 8'h3F;
   localparam logic [7:0] ChCr    = 8'h0D;
   localparam logic [7:0] ChLf    = 8'h0A;
   localparam logic [7:0] ChK     = 8'h4B;
   localparam logic [7:0] ChE     = 8'h45;

   typedef enum logic [2:0] {StIdle, StArg1, StArg2, StResp, StWaitTx} state_e;

   state_e      state_q, state_d;
   logic        cmd_disp_q;
   logic [3:0]  hi_nib_q;
   logic        pend_q;
   logic [3:0]  pend_val_q;
   logic [31:0] cnt_q;

   logic        rx_hex_ok;
   logic [3:0]  rx_nib;
   logic [7:0]  pat_ascii;
   logic        timeout;
   logic        in_arg;
   logic        reply_req;
   logic [7:0]  reply_byte;
   logic        err_now;
   logic        pend_load;
   logic        disp_load;
   logic        hi_load;
   logic        tx_dv_d;

   always_comb begin
      rx_hex_ok = 1'b1;
      rx_nib    = 4'h0;
      if (i_RX_Byte >= 8'h30 && i_RX_Byte <= 8'h39) begin
         rx_nib = i_RX_Byte[3:0];
      end else if ((i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h46) ||
                   (i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h66)) begin
         rx_nib = i_RX_Byte[3:0] + 4'd9;
      end else begin
         rx_hex_ok = 1'b0;
      end
   end

   assign pat_ascii = (o_Pattern < 4'd10) ? {4'h3, o_Pattern} : ({4'h0, o_Pattern} + 8'h37);
   assign timeout   = (cnt_q == 32'(TIMEOUT_CLKS - 1));
   assign in_arg    = (state_q == StArg1) || (state_q == StArg2);

   always_comb begin
      state_d    = state_q;
      reply_req  = 1'b0;
      reply_byte = ChK;
      err_now    = 1'b0;
      pend_load  = 1'b0;
      disp_load  = 1'b0;
      hi_load    = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_RX_DV) begin
               if (i_RX_Byte == ChP || i_RX_Byte == ChD) begin
                  state_d = StArg1;
               end else if (i_RX_Byte == ChQuery) begin
                  reply_req  = 1'b1;
                  reply_byte = pat_ascii;
               end else if (i_RX_Byte != ChCr && i_RX_Byte != ChLf) begin
                  reply_req  = 1'b1;
                  reply_byte = ChE;
                  err_now    = 1'b1;
               end
            end
         end
         StArg1, StArg2: begin
            // A byte arriving in the timeout cycle takes priority over the abort.
            if (i_RX_DV) begin
               if (!rx_hex_ok) begin
                  reply_req  = 1'b1;
                  reply_byte = ChE;
                  err_now    = 1'b1;
               end else if (state_q == StArg2) begin
                  disp_load = 1'b1;
                  reply_req = 1'b1;
               end else if (cmd_disp_q) begin
                  hi_load = 1'b1;
                  state_d = StArg2;
               end else begin
                  pend_load = 1'b1;
                  reply_req = 1'b1;
               end
            end else if (timeout) begin
               reply_req  = 1'b1;
               reply_byte = ChE;
               err_now    = 1'b1;
            end
         end
         StResp: begin
            if (!i_TX_Active) state_d = StWaitTx;
         end
         StWaitTx: begin
            if (i_TX_Done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (reply_req) state_d = i_TX_Active ? StResp : StWaitTx;
   end

   assign tx_dv_d = !i_TX_Active && (reply_req || state_q == StResp);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q        <= StIdle;
         cmd_disp_q     <= 1'b0;
         hi_nib_q       <= 4'h0;
         pend_q         <= 1'b0;
         pend_val_q     <= 4'h0;
         cnt_q          <= 32'd0;
         o_TX_DV        <= 1'b0;
         o_TX_Byte      <= 8'h00;
         o_Pattern      <= RESET_PATTERN;
         o_Display_Byte <= 8'h00;
         o_Busy         <= 1'b0;
         o_Err          <= 1'b0;
      end else begin
         state_q <= state_d;
         o_Busy  <= (state_d != StIdle);
         o_Err   <= err_now;
         o_TX_DV <= tx_dv_d;
         cnt_q   <= (in_arg && !i_RX_DV) ? cnt_q + 32'd1 : 32'd0;
         if (reply_req) o_TX_Byte <= reply_byte;
         if (state_q == StIdle && i_RX_DV) cmd_disp_q <= (i_RX_Byte == ChD);
         if (hi_load) hi_nib_q <= rx_nib;
         if (disp_load) o_Display_Byte <= {hi_nib_q, rx_nib};
         // A load coinciding with a frame start waits for the next frame.
         if (pend_load) begin
            pend_val_q <= rx_nib;
            pend_q     <= 1'b1;
         end else if (i_Frame_Start && pend_q) begin
            o_Pattern <= pend_val_q;
            pend_q    <= 1'b0;
         end
      end
   end

endmodule
